// File: rtl/perf_pkg.sv
// perf_pkg
// Shared types and constants for the performance counter bank.
//   cnt_mode_t  : per-channel counting mode (cycle-level or rising-edge)
//   CH_*        : channel assignment used when hooking the bank to the CPU
//                 and cache controllers
//   is_hit()    : event qualification shared by every channel
package perf_pkg;

  typedef enum logic {
    CNT_LEVEL = 1'b0,  // count every cycle the event is high
    CNT_EDGE  = 1'b1   // count 0->1 transitions of the event
  } cnt_mode_t;

  localparam int CH_IMEM_STALL   = 0;
  localparam int CH_DMEM_STALL   = 1;
  localparam int CH_FLUSH        = 2;
  localparam int CH_DCACHE_MISS  = 3;
  localparam int CH_ICACHE_MISS  = 4;
  localparam int CH_DCACHE_EVICT = 5;
  localparam int CH_ALLOC_CYC    = 6;
  localparam int CH_WB_CYC       = 7;

  // Qualify a raw event strobe against the previous-cycle sample.
  function automatic logic is_hit(input cnt_mode_t m, input logic ev,
                                  input logic prv);
    return (m == CNT_EDGE) ? (ev & ~prv) : ev;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if
// Readout port of the counter bank.
//   rd_req   : read request (master -> slave)
//   rd_idx   : channel index to read (master -> slave)
//   rd_valid : response valid, one cycle after rd_req (slave -> master)
//   rd_data  : shadow counter value of the addressed channel
//   rd_ovf   : shadow overflow flag of the addressed channel
//   rd_err   : index out of range
// master = the reader (CPU/debug side), slave = the counter bank.
interface perf_counter_bank_if #(
  parameter int IDX_WIDTH = 3,
  parameter int CNT_WIDTH = 64
) ();

  logic                 rd_req;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic                 rd_valid;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_ovf;
  logic                 rd_err;

  modport master (
    output rd_req,
    output rd_idx,
    input  rd_valid,
    input  rd_data,
    input  rd_ovf,
    input  rd_err
  );

  modport slave (
    input  rd_req,
    input  rd_idx,
    output rd_valid,
    output rd_data,
    output rd_ovf,
    output rd_err
  );

endinterface

// File: rtl/perf_counter_ch.sv
// perf_counter_ch
// One saturating event counter with a snapshot shadow.
//   clk, rst    : clock, asynchronous active-low reset
//   enable      : global count enable
//   clear       : synchronous clear of counter and sticky overflow
//   snap        : copy live counter/overflow into the shadow registers
//   mode        : CNT_LEVEL or CNT_EDGE
//   event_in    : event strobe, synchronous to clk
//   ovf         : live sticky saturation flag
//   shadow      : snapshot of the counter
//   shadow_ovf  : snapshot of ovf
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 snap,
  input  cnt_mode_t            mode,
  input  logic                 event_in,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 shadow_ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 prev;
  logic [CNT_WIDTH-1:0] count;
  logic                 hit;
  logic                 at_max;

  assign hit    = is_hit(mode, event_in, prev);
  assign at_max = &count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= 1'b0;
      count      <= '0;
      ovf        <= 1'b0;
      shadow     <= '0;
      shadow_ovf <= 1'b0;
    end else begin
      // prev tracks the raw strobe every cycle so that re-enabling while the
      // event is held high never looks like a fresh edge.
      prev <= event_in;

      // Shadow takes the pre-update values, so snap+clear in one cycle
      // preserves the counts that are being cleared.
      if (snap) begin
        shadow     <= count;
        shadow_ovf <= ovf;
      end

      if (clear) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (enable && hit) begin
        if (at_max) begin
          ovf <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// Bank of NUM_CH saturating performance counters with snapshot readout.
//   clk, rst  : clock, asynchronous active-low reset
//   enable    : global count enable
//   clear     : synchronous clear of all live counters and ovf flags
//   mode      : per-channel mode bit (0 = level, 1 = edge)
//   event_in  : per-channel event strobes
//   snap      : capture all live counters into shadows
//   rd        : readout port (slave side), one response per request,
//               one cycle latency, no backpressure
//   ovf       : live sticky saturation flags
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int CNT_WIDTH = 64,
  parameter int IDX_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              snap,
  perf_counter_bank_if.slave rd,
  output logic [NUM_CH-1:0] ovf
);

  logic [CNT_WIDTH-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0]    shadow_ovf;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_counter_ch #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clear      (clear),
      .snap       (snap),
      .mode       (cnt_mode_t'(mode[g])),
      .event_in   (event_in[g]),
      .ovf        (ovf[g]),
      .shadow     (shadow[g]),
      .shadow_ovf (shadow_ovf[g])
    );
  end

  // Read mux over the shadows. Indices with no channel select nothing and
  // leave the mux outputs at zero.
  logic [CNT_WIDTH-1:0] sel_data;
  logic                 sel_ovf;
  logic                 idx_err;

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd.rd_idx == IDX_WIDTH'(i)) begin
        sel_data = shadow[i];
        sel_ovf  = shadow_ovf[i];
      end
    end
  end

  assign idx_err = (int'(rd.rd_idx) >= NUM_CH);

  // Response registers. The mux reads the shadows as they stand before this
  // edge, so a snap in the request cycle does not disturb the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_ovf   <= 1'b0;
      rd.rd_err   <= 1'b0;
    end else begin
      rd.rd_valid <= rd.rd_req;
      if (rd.rd_req) begin
        rd.rd_err  <= idx_err;
        rd.rd_ovf  <= idx_err ? 1'b0 : sel_ovf;
        rd.rd_data <= idx_err ? '0 : sel_data;
      end else begin
        // rd_data deliberately holds its last value between responses.
        rd.rd_err <= 1'b0;
        rd.rd_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank
// Self-checking bench for perf_counter_bank. Read responses are predicted
// when a request is issued and compared from a queue when rd_valid appears.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NUM_CH    = 6;
  localparam int CNT_WIDTH = 8;
  localparam int IDX_WIDTH = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              snap = 1'b0;
  logic [NUM_CH-1:0] mode = '0;
  logic [NUM_CH-1:0] event_in = '0;
  logic [NUM_CH-1:0] ovf;

  perf_counter_bank_if #(.IDX_WIDTH(IDX_WIDTH), .CNT_WIDTH(CNT_WIDTH)) rd_if ();

  perf_counter_bank #(
    .NUM_CH    (NUM_CH),
    .CNT_WIDTH (CNT_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (clear),
    .mode     (mode),
    .event_in (event_in),
    .snap     (snap),
    .rd       (rd_if),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   idx;
    logic [CNT_WIDTH-1:0] data;
    logic                 ovf;
    logic                 err;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; sample 1 time unit after the edge and retire one
  // predicted read response if one is due.
  task automatic cycle();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== e.data ||
          rd_if.rd_ovf !== e.ovf || rd_if.rd_err !== e.err) begin
        errors++;
        $display("FAIL read_idx%0d: got valid=%b data=%0d ovf=%b err=%b, want valid=1 data=%0d ovf=%b err=%b",
                 e.idx, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_ovf, rd_if.rd_err,
                 e.data, e.ovf, e.err);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic snap_once();
    snap = 1'b1;
    cycle();
    snap = 1'b0;
  endtask

  task automatic issue_read(input int idx, input int data, input logic o, input logic err);
    rd_exp_t e;
    e.idx  = idx;
    e.data = CNT_WIDTH'(data);
    e.ovf  = o;
    e.err  = err;
    rd_if.rd_req = 1'b1;
    rd_if.rd_idx = IDX_WIDTH'(idx);
    exp_q.push_back(e);
    cycle();
    rd_if.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rd_if.rd_req = 1'b0;
    rd_if.rd_idx = '0;
    #13;
    checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== '0 || rd_if.rd_ovf !== 1'b0 ||
        rd_if.rd_err !== 1'b0 || ovf !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%0d ovf=%b err=%b ovf_vec=%b, want all 0",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_ovf, rd_if.rd_err, ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_level();
    enable = 1'b1;
    mode   = 6'b000010;
    event_in[0] = 1'b1;
    run(5);
    event_in[0] = 1'b0;
    snap_once();
    issue_read(0, 5, 1'b0, 1'b0);
    cycle();
    checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_ovf !== 1'b0 || rd_if.rd_err !== 1'b0 ||
        rd_if.rd_data !== 8'd5) begin
      errors++;
      $display("FAIL level_idle: got valid=%b ovf=%b err=%b data=%0d, want valid=0 ovf=0 err=0 data=5",
               rd_if.rd_valid, rd_if.rd_ovf, rd_if.rd_err, rd_if.rd_data);
    end
  endtask

  task automatic test_edge();
    logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    foreach (pat[i]) begin
      event_in[1] = pat[i];
      cycle();
    end
    enable = 1'b0;
    run(2);
    enable = 1'b1;
    run(2);
    event_in[1] = 1'b0;
    cycle();
    snap_once();
    issue_read(1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    event_in[2] = 1'b1;
    run(255);
    checks++;
    if (ovf[2] !== 1'b0) begin
      errors++;
      $display("FAIL sat_at_max: got ovf[2]=%b, want 0", ovf[2]);
    end
    cycle();
    checks++;
    if (ovf !== 6'b000100) begin
      errors++;
      $display("FAIL sat_ovf_set: got ovf=%b, want 000100", ovf);
    end
    run(44);
    event_in[2] = 1'b0;
    snap_once();
    issue_read(2, 255, 1'b1, 1'b0);
    run(3);
    checks++;
    if (ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky: got ovf[2]=%b, want 1", ovf[2]);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (ovf !== '0) begin
      errors++;
      $display("FAIL sat_clear: got ovf=%b, want 000000", ovf);
    end
    snap_once();
    issue_read(2, 0, 1'b0, 1'b0);
    issue_read(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    event_in[3] = 1'b1;
    run(10);
    snap  = 1'b1;
    clear = 1'b1;
    cycle();
    snap  = 1'b0;
    clear = 1'b0;
    event_in[3] = 1'b0;
    issue_read(3, 10, 1'b0, 1'b0);
    snap_once();
    issue_read(3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_port();
    issue_read(NUM_CH, 0, 1'b0, 1'b1);
    issue_read(7, 0, 1'b0, 1'b1);
    cycle();
    checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL err_idle: got valid=%b err=%b, want 0 0", rd_if.rd_valid, rd_if.rd_err);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    event_in = 6'b000101;
    run(4);
    event_in = 6'b000100;
    run(3);
    event_in = 6'b000010;
    cycle();
    event_in = '0;
    cycle();
    snap_once();
    issue_read(0, 4, 1'b0, 1'b0);
    issue_read(1, 1, 1'b0, 1'b0);
    issue_read(2, 7, 1'b0, 1'b0);
    cycle();
    checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'd7) begin
      errors++;
      $display("FAIL b2b_end: got valid=%b data=%0d, want valid=0 data=7",
               rd_if.rd_valid, rd_if.rd_data);
    end
  endtask

  task automatic test_back_to_back_reset();
    event_in[0] = 1'b1;
    run(4);
    snap_once();
    rd_if.rd_req = 1'b1;
    rd_if.rd_idx = '0;
    @(posedge clk);
    #1;
    checks++;
    if (rd_if.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pending: got valid=%b, want 1", rd_if.rd_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== '0 || rd_if.rd_ovf !== 1'b0 ||
        rd_if.rd_err !== 1'b0 || ovf !== '0) begin
      errors++;
      $display("FAIL rst_async: got valid=%b data=%0d ovf=%b err=%b ovf_vec=%b, want all 0",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_ovf, rd_if.rd_err, ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_held: got valid=%b, want 0", rd_if.rd_valid);
    end
    rd_if.rd_req = 1'b0;
    #2;
    rst = 1'b1;
    cycle();
    checks++;
    if (rd_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got valid=%b, want 0", rd_if.rd_valid);
    end
    run(2);
    event_in[0] = 1'b0;
    snap_once();
    issue_read(0, 3, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_saturation();
    test_simultaneous();
    test_read_port();
    test_back_to_back_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending responses, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable bank of NUM_CH event counters for on-chip performance measurement: imem/dmem stall cycles, branch flushes, cache misses, evictions, allocate and writeback cycles. It sits beside the CPU and cache controllers and takes one single-bit event strobe per channel. Each channel has its own count mode, saturates with a sticky overflow flag, and is read through a snapshot/readout port, so the metrics no longer depend on testbench-only probes.

## Interface
Parameters:
- NUM_CH, 8, number of counter channels (1..64)
- CNT_WIDTH, 64, counter width in bits (8..64)
- IDX_WIDTH, $clog2(NUM_CH) (min 1), width of the read index

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  global count enable
- clear  in  1  synchronous clear of all counters and overflow flags
- mode  in  NUM_CH  per-channel mode; 0 = CNT_LEVEL (count cycles where the event is high), 1 = CNT_EDGE (count 0→1 transitions)
- event_in  in  NUM_CH  event strobes, synchronous to clk
- snap  in  1  copies all live counters into shadow registers
- rd_req  in  1  read request
- rd_idx  in  IDX_WIDTH  channel to read
- rd_valid  out  1  read data valid
- rd_data  out  CNT_WIDTH  shadow value of the channel
- rd_ovf  out  1  shadow overflow flag of the channel
- rd_err  out  1  rd_idx >= NUM_CH
- ovf  out  NUM_CH  live sticky saturation flags

## Operation
- Per channel: prev register holds event_in from the previous cycle.
  - hit = event_in in CNT_LEVEL.
  - hit = event_in & ~prev in CNT_EDGE.
- Increment when enable & hit & ~clear.
  - If the counter is all-ones, it holds its value and ovf sets.
  - ovf is sticky until clear or reset. It never wraps.
- prev updates every cycle regardless of enable or clear. Re-enabling while an event is held high therefore produces no spurious edge.
- A mode change takes effect the same cycle. prev is unaffected by a mode change.
- clear: counters and ovf go to 0 on the next edge. Shadows are untouched.
- snap: shadow[i] <= live counter value before this cycle's increment. shadow_ovf[i] <= ovf[i].
  - snap and clear in the same cycle: the shadow captures the pre-clear values, and the live counters clear.
- Read:
  - rd_req in cycle N gives rd_valid=1 in cycle N+1, holding shadow[rd_idx] and shadow_ovf[rd_idx] as they were at the N edge.
  - A snap in cycle N does not affect that read.
  - rd_idx >= NUM_CH gives rd_data=0, rd_ovf=0, rd_err=1.
  - Back-to-back reads are allowed, one per cycle. There is no backpressure.
- rd_valid, rd_err, and rd_ovf are 0 in any cycle without a read response. rd_data holds its last value.

## Timing
- Reset (rst=0, asynchronous) sets to 0: counters, shadows, ovf, shadow_ovf, prev, rd_valid, rd_data, rd_ovf, rd_err.
  - Deassertion is synchronized externally.
  - Reset in the middle of a read cancels the response.
- Event to counter visible: 1 cycle (registered).
- Event to readable: event edge, then snap, then rd_req, then rd_valid. The minimum is 3 cycles.
- The increment path is CNT_WIDTH wide. A single-cycle ripple is acceptable at the project clock. No pipelining of the counter.

## Structure
- Package perf_pkg holds:
  - typedef enum logic {CNT_LEVEL, CNT_EDGE} cnt_mode_t
  - shared channel index localparams for the CPU hookup: CH_IMEM_STALL=0, CH_DMEM_STALL=1, CH_FLUSH=2, CH_DCACHE_MISS=3, CH_ICACHE_MISS=4, CH_DCACHE_EVICT=5, CH_ALLOC_CYC=6, CH_WB_CYC=7
- Sub-module perf_counter_ch implements one channel: prev, counter, ovf, shadow, shadow_ovf. It is instantiated NUM_CH times by generate.
- The top level adds the read mux and output registers.

## Test plan
- Level count: mode[0]=0, enable=1, event_in[0] high for 5 cycles, then snap, then rd_req idx 0 -> rd_data=5, rd_ovf=0, rd_err=0.
- Edge count: mode[1]=1, event_in[1] pattern 1,1,0,1,0,1,1 -> count 3. Drop enable while event_in[1] is high, raise enable while it is still high -> count stays 3.
- Saturation: CNT_WIDTH=8, level event for 300 cycles -> rd_data=255, rd_ovf=1, ovf[ch]=1 until clear. After clear -> ovf=0, counter 0.
- Simultaneous: counter at 10 with an event high, snap+clear in the same cycle -> shadow=10, live=0. Next read returns 10. A second snap returns 0.
- Read port: rd_idx=NUM_CH -> rd_err=1, rd_data=0. Back-to-back reads of idx 0,1,2 -> three consecutive rd_valid cycles with the correct values.
- Async reset: assert rst=0 mid-count, between clock edges, with rd_req pending -> all outputs 0 immediately, no rd_valid after release, counters restart from 0.
